// File: rtl/matmul_pkg.sv
// Shared types and widths for the matrix-multiply sequencer.
package matmul_pkg;

  localparam int DATA_W  = 8;   // signed operand width
  localparam int ACC_W   = 19;  // signed dot-product width
  localparam int MAC_LAT = 2;   // cycles from operand pair to mac_out

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WAIT2,
    WRITE,
    FIN
  } state_t;

endpackage

// File: rtl/matmul_idx_counter.sv
// Nested i/j/k loop counters with wrap flags and A/B/C address generation.
module matmul_idx_counter #(
  parameter int N  = 4,
  parameter int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          k_inc,
  input  logic          j_inc,
  output logic          k_first,
  output logic          k_last,
  output logic          j_last,
  output logic          i_last,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic [AW-1:0] c_addr
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] i, j, k;

  assign k_first = (k == '0);
  assign k_last  = (k == LAST);
  assign j_last  = (j == LAST);
  assign i_last  = (i == LAST);

  assign a_addr = AW'(i) * AW'(N) + AW'(k);
  assign b_addr = AW'(k) * AW'(N) + AW'(j);
  assign c_addr = AW'(i) * AW'(N) + AW'(j);

  // k steps per issued pair; j steps per written element and carries into i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (k_inc) k <= k_last ? '0 : k + 1'b1;
      if (j_inc) begin
        j <= j_last ? '0 : j + 1'b1;
        if (j_last) i <= i_last ? '0 : i + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences A/B operand reads into the MAC and writes each dot product to C.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_rdata,
  output logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clear,
  input  logic [ACC_W-1:0]  mac_out,
  output logic              c_we,
  output logic [AW-1:0]     c_addr,
  output logic [ACC_W-1:0]  c_wdata
);

  state_t state, state_nx;
  logic   clr, k_inc, j_inc;
  logic   k_first, k_last, j_last, i_last;
  logic   feed_q, clear_q;

  matmul_idx_counter #(.N(N), .AW(AW)) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .k_inc   (k_inc),
    .j_inc   (j_inc),
    .k_first (k_first),
    .k_last  (k_last),
    .j_last  (j_last),
    .i_last  (i_last),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .c_addr  (c_addr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and counter control.
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    k_inc    = 1'b0;
    j_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          clr      = 1'b1;
        end
      end
      ISSUE: begin
        k_inc = 1'b1;
        if (k_last) state_nx = WAIT;
      end
      WAIT:  state_nx = WAIT2;
      WAIT2: state_nx = WRITE;
      WRITE: begin
        j_inc    = 1'b1;
        state_nx = (i_last && j_last) ? FIN : ISSUE;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Feed stage: aligns the clear strobe and valid flag with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feed_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      feed_q  <= (state == ISSUE);
      clear_q <= (state == ISSUE) && k_first;
    end
  end

  assign mac_a     = feed_q ? a_rdata : '0;
  assign mac_b     = feed_q ? b_rdata : '0;
  assign mac_clear = clear_q || (state == IDLE);

  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign c_we    = (state == WRITE);
  assign c_wdata = mac_out;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: N=4 and N=2 instances, behavioural RAMs and MACs.
module tb_matmul_sequencer;

  localparam int NA  = 4;
  localparam int NB  = 2;
  localparam int AW4 = $clog2(NA*NA);
  localparam int AW2 = $clog2(NB*NB);
  localparam int L4  = NA*NA*(NA+3);
  localparam int L2  = NB*NB*(NB+3);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic start4 = 1'b0;
  logic start2 = 1'b0;

  logic                   busy4, done4, mac_clear4, c_we4;
  logic [AW4-1:0]         a_addr4, b_addr4, c_addr4;
  logic signed [7:0]      a_rdata4, b_rdata4, mac_a4, mac_b4;
  logic signed [18:0]     mac_out4, c_wdata4, acc4;

  logic                   busy2, done2, mac_clear2, c_we2;
  logic [AW2-1:0]         a_addr2, b_addr2, c_addr2;
  logic signed [7:0]      a_rdata2, b_rdata2, mac_a2, mac_b2;
  logic signed [18:0]     mac_out2, c_wdata2, acc2;

  logic signed [7:0] mem_a [2][64];
  logic signed [7:0] mem_b [2][64];

  matmul_sequencer #(.N(NA)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
    .a_addr(a_addr4), .a_rdata(a_rdata4), .b_addr(b_addr4), .b_rdata(b_rdata4),
    .mac_a(mac_a4), .mac_b(mac_b4), .mac_clear(mac_clear4), .mac_out(mac_out4),
    .c_we(c_we4), .c_addr(c_addr4), .c_wdata(c_wdata4)
  );

  matmul_sequencer #(.N(NB)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .a_addr(a_addr2), .a_rdata(a_rdata2), .b_addr(b_addr2), .b_rdata(b_rdata2),
    .mac_a(mac_a2), .mac_b(mac_b2), .mac_clear(mac_clear2), .mac_out(mac_out2),
    .c_we(c_we2), .c_addr(c_addr2), .c_wdata(c_wdata2)
  );

  // 1-cycle read RAMs and 2-stage MACs (accumulate, then output register).
  always @(posedge clk) begin
    a_rdata4 <= mem_a[0][a_addr4];
    b_rdata4 <= mem_b[0][b_addr4];
    a_rdata2 <= mem_a[1][a_addr2];
    b_rdata2 <= mem_b[1][b_addr2];
    acc4     <= (mac_clear4 ? 19'sd0 : acc4) + 19'(mac_a4) * 19'(mac_b4);
    mac_out4 <= acc4;
    acc2     <= (mac_clear2 ? 19'sd0 : acc2) + 19'(mac_a2) * 19'(mac_b2);
    mac_out2 <= acc2;
  end

  // Model state: accept cycle per instance and golden C computed at accept time.
  int cyc = 0;
  int acc_cyc [2];
  bit active [2];
  int gold [2][64];
  int pin [2];
  int vectors = 0;
  int fails = 0;

  // Model: a run is accepted on start when the previous run has fully returned to idle.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int n, L, s;
      bit st;
      n  = (d == 0) ? NA : NB;
      L  = n*n*(n+3);
      st = (d == 0) ? start4 : start2;
      if (!rst_n) begin
        active[d] = 1'b0;
      end else if (st && (!active[d] || (cyc - acc_cyc[d]) >= L + 2)) begin
        active[d]  = 1'b1;
        acc_cyc[d] = cyc;
        for (int i = 0; i < n; i++)
          for (int j = 0; j < n; j++) begin
            s = 0;
            for (int k = 0; k < n; k++)
              s += int'(mem_a[d][i*n+k]) * int'(mem_b[d][k*n+j]);
            gold[d][i*n+j] = s;
          end
      end
    end
    cyc++;
  end

  task automatic chk(input string nm, input int d, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, d, cyc, act, exp);
    end
  endtask

  // Compare DUT outputs with the model every cycle and right after reset assertion.
  always @(negedge clk or negedge rst_n) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      int n, L, o, ph, e, ca, wd;
      bit idle, bz, dn, we, cl, exp_we;
      n = (d == 0) ? NA : NB;
      L = n*n*(n+3);
      if (d == 0) begin
        bz = busy4; dn = done4; we = c_we4; cl = mac_clear4;
        ca = int'(c_addr4); wd = int'(c_wdata4);
      end else begin
        bz = busy2; dn = done2; we = c_we2; cl = mac_clear2;
        ca = int'(c_addr2); wd = int'(c_wdata2);
      end
      o    = cyc - acc_cyc[d];
      idle = !rst_n || !active[d] || o >= L + 2;
      if (idle) begin
        chk("busy_idle", d, int'(bz), 0);
        chk("done_idle", d, int'(dn), 0);
        chk("c_we_idle", d, int'(we), 0);
        chk("clear_idle", d, int'(cl), 1);
      end else begin
        ph     = (o - 1) % (n + 3);
        e      = (o - 1) / (n + 3);
        exp_we = (o - 1 < L) && (ph == n + 2);
        chk("busy", d, int'(bz), 1);
        chk("done", d, int'(dn), int'(o == L + 1));
        chk("c_we", d, int'(we), int'(exp_we));
        chk("mac_clear", d, int'(cl), int'((o - 1 < L) && (ph == 1)));
        if (exp_we) begin
          chk("c_addr", d, ca, e);
          chk("c_wdata", d, wd, gold[d][e]);
          case (pin[d])
            1: chk("lit_identity", d, wd, e);
            2: chk("lit_neg_sq", d, wd, 65536);
            3: chk("lit_mixed", d, wd, -65024);
            4: begin
              int lit [4];
              lit = '{19, 22, 43, 50};
              chk("lit_2x2", d, wd, lit[e]);
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic run4();
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    tick(L4 + 4);
  endtask

  initial begin
    pin[0] = 0;
    pin[1] = 0;
    for (int x = 0; x < 64; x++) begin
      mem_a[0][x] = '0; mem_b[0][x] = '0;
      mem_a[1][x] = '0; mem_b[1][x] = '0;
    end
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Identity times B, B[r][c] = r*4+c
    for (int r = 0; r < NA; r++)
      for (int c = 0; c < NA; c++) begin
        mem_a[0][r*NA+c] = (r == c) ? 8'sd1 : 8'sd0;
        mem_b[0][r*NA+c] = 8'(r*NA + c);
      end
    pin[0] = 1;
    run4();

    // Extreme magnitudes
    for (int x = 0; x < NA*NA; x++) begin
      mem_a[0][x] = -8'sd128;
      mem_b[0][x] = -8'sd128;
    end
    pin[0] = 2;
    run4();
    for (int x = 0; x < NA*NA; x++) mem_a[0][x] = 8'sd127;
    pin[0] = 3;
    run4();

    // start held high: one run, re-accept in the first idle cycle only
    start4 = 1'b1;
    tick(200);
    start4 = 1'b0;
    tick(L4 + 4);

    // Reset 50 cycles into a run, then a clean run
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    tick(49);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run4();

    // Random operands
    for (int x = 0; x < NA*NA; x++) begin
      mem_a[0][x] = 8'($urandom_range(255));
      mem_b[0][x] = 8'($urandom_range(255));
    end
    mem_a[0][0] = -8'sd128;
    mem_b[0][15] = 8'sd127;
    pin[0] = 0;
    run4();

    // N=2 instance
    mem_a[1][0] = 8'sd1; mem_a[1][1] = 8'sd2; mem_a[1][2] = 8'sd3; mem_a[1][3] = 8'sd4;
    mem_b[1][0] = 8'sd5; mem_b[1][1] = 8'sd6; mem_b[1][2] = 8'sd7; mem_b[1][3] = 8'sd8;
    pin[1] = 4;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(L2 + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
